fetch_bp: RTL and testbench



---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_btb.sv | 80 ++++++++
 rtl/fetch_bp.sv | 96 +++++++++
 tb/tb_fetch_bp.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the fetch unit: default widths, reset/exception vectors
// and the 2-bit branch direction counter encoding.
package fetch_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_1000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_2000;

    // Saturating direction counter; bit 1 set means predict taken.
    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } ctr_e;

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on the current PC; training happens at the clock edge,
// so a same-index lookup in the update cycle still sees the old contents.
module fetch_btb
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEF,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    output logic            hit_taken_o,
    output logic [XLEN-1:0] hit_target_o
);

    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;

    logic             valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]  target_q [BTB_ENTRIES];
    ctr_e             ctr_q    [BTB_ENTRIES];

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX-1:0]   up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             lk_hit;
    logic             up_hit;

    // Byte-offset bits never take part in index/tag selection.
    logic unused_offset;
    assign unused_offset = ^{pc_i[1:0], upd_pc_i[1:0]};

    assign lk_idx = pc_i[IDX+1:2];
    assign lk_tag = pc_i[XLEN-1:IDX+2];
    assign up_idx = upd_pc_i[IDX+1:2];
    assign up_tag = upd_pc_i[XLEN-1:IDX+2];

    // Combinational lookup of the current fetch PC.
    always_comb begin
        lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        hit_taken_o  = lk_hit && ctr_q[lk_idx][1];
        hit_target_o = target_q[lk_idx];
    end

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Training: counter walk on hit, allocate on taken miss; reset wins over all.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (upd_valid_i) begin
            if (up_hit) begin
                if (upd_taken_i) begin
                    if (ctr_q[up_idx] != CTR_ST) begin
                        ctr_q[up_idx] <= ctr_e'(2'(ctr_q[up_idx] + 2'd1));
                    end
                    target_q[up_idx] <= upd_target_i;
                end else if (ctr_q[up_idx] != CTR_SNT) begin
                    ctr_q[up_idx] <= ctr_e'(2'(ctr_q[up_idx] - 2'd1));
                end
            end else if (upd_taken_i) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target_i;
                ctr_q[up_idx]    <= CTR_WT;
            end
        end
    end

endmodule

// File: rtl/fetch_bp.sv
// Fetch PC unit: holds the program counter and picks the next PC by priority
// (exception, return, mispredict, jump, stall, predicted/sequential flow).
module fetch_bp
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN        = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEF),
    parameter logic [XLEN-1:0] EXC_PC      = XLEN'(EXC_PC_DEF),
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter bit              BP_EN       = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_core_i,
    input  logic            exc_occured_i,
    input  logic            iret_i,
    input  logic [XLEN-1:0] exc_return_pc_i,
    input  logic            redir_i,
    input  logic [XLEN-1:0] redir_pc_i,
    input  logic            jal_i,
    input  logic [XLEN-1:0] jal_pc_i,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic            btb_taken;
    logic [XLEN-1:0] btb_target;

    assign pc_plus4 = pc_q + XLEN'(4);

    generate
        if (BP_EN) begin : g_btb
            fetch_btb #(
                .XLEN        (XLEN),
                .BTB_ENTRIES (BTB_ENTRIES)
            ) u_btb (
                .clk_i        (clk_i),
                .rst_i        (rst_i),
                .pc_i         (pc_q),
                .upd_valid_i  (upd_valid_i),
                .upd_pc_i     (upd_pc_i),
                .upd_taken_i  (upd_taken_i),
                .upd_target_i (upd_target_i),
                .hit_taken_o  (btb_taken),
                .hit_target_o (btb_target)
            );
        end else begin : g_no_btb
            logic unused_upd;
            assign unused_upd = ^{upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i};
            assign btb_taken  = 1'b0;
            assign btb_target = '0;
        end
    endgenerate

    // Prediction is combinational from the current PC and BTB contents.
    always_comb begin
        pred_taken_o = btb_taken;
        pred_pc_o    = btb_taken ? btb_target : pc_plus4;
    end

    // Next-PC priority mux; a stall only blocks the sequential/predicted advance.
    always_comb begin
        pc_d = pc_q;
        if (exc_occured_i) begin
            pc_d = EXC_PC;
        end else if (iret_i) begin
            pc_d = exc_return_pc_i;
        end else if (redir_i) begin
            pc_d = redir_pc_i;
        end else if (jal_i) begin
            pc_d = jal_pc_i;
        end else if (!stall_core_i) begin
            pc_d = pred_pc_o;
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: tb/tb_fetch_bp.sv
// Directed self-checking bench for fetch_bp (default parameters).
module tb_fetch_bp;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_core_i;
    logic        exc_occured_i;
    logic        iret_i;
    logic [31:0] exc_return_pc_i;
    logic        redir_i;
    logic [31:0] redir_pc_i;
    logic        jal_i;
    logic [31:0] jal_pc_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic [31:0] pc_o;
    logic        pred_taken_o;
    logic [31:0] pred_pc_o;

    int n_checks = 0;
    int n_errors = 0;

    fetch_bp dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_core_i    (stall_core_i),
        .exc_occured_i   (exc_occured_i),
        .iret_i          (iret_i),
        .exc_return_pc_i (exc_return_pc_i),
        .redir_i         (redir_i),
        .redir_pc_i      (redir_pc_i),
        .jal_i           (jal_i),
        .jal_pc_i        (jal_pc_i),
        .upd_valid_i     (upd_valid_i),
        .upd_pc_i        (upd_pc_i),
        .upd_taken_i     (upd_taken_i),
        .upd_target_i    (upd_target_i),
        .pc_o            (pc_o),
        .pred_taken_o    (pred_taken_o),
        .pred_pc_o       (pred_pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic pt,
                             input logic [31:0] ppc);
        chk({tag, ".pc"}, pc_o, pc);
        chk({tag, ".pred_taken"}, 32'(pred_taken_o), 32'(pt));
        chk({tag, ".pred_pc"}, pred_pc_o, ppc);
    endtask

    task automatic clear_inputs();
        rst_i = 0; stall_core_i = 0; exc_occured_i = 0; iret_i = 0;
        exc_return_pc_i = '0; redir_i = 0; redir_pc_i = '0; jal_i = 0; jal_pc_i = '0;
        upd_valid_i = 0; upd_pc_i = '0; upd_taken_i = 0; upd_target_i = '0;
    endtask

    initial begin
        clear_inputs();

        // Reset and free-run
        rst_i = 1; tick();
        chk_state("reset", 32'h1000, 1'b0, 32'h1004);
        rst_i = 0; tick();
        chk_state("run1", 32'h1004, 1'b0, 32'h1008);
        tick();
        chk_state("run2", 32'h1008, 1'b0, 32'h100C);
        tick();
        chk_state("run3", 32'h100C, 1'b0, 32'h1010);

        // Back to 0x1008 then stall, jump during second stall cycle
        rst_i = 1; tick(); rst_i = 0; tick(); tick();
        chk("pre_stall.pc", pc_o, 32'h1008);
        stall_core_i = 1; tick();
        chk("stall_hold.pc", pc_o, 32'h1008);
        jal_i = 1; jal_pc_i = 32'h1400; tick();
        chk("stall_jal.pc", pc_o, 32'h1400);
        jal_i = 0;

        // Exception beats every other redirect, even while stalled
        exc_occured_i = 1; iret_i = 1; exc_return_pc_i = 32'h1010;
        redir_i = 1; redir_pc_i = 32'h3000; jal_i = 1; jal_pc_i = 32'h1400;
        tick();
        chk("exc_prio.pc", pc_o, 32'h2000);
        exc_occured_i = 0; redir_i = 0; jal_i = 0;
        tick();
        chk_state("iret", 32'h1010, 1'b0, 32'h1014);
        iret_i = 0;

        // Train at 0x1010 while holding there; lookup sees pre-update state
        upd_valid_i = 1; upd_pc_i = 32'h1010; upd_taken_i = 1; upd_target_i = 32'h1100;
        #1;
        chk("no_bypass.pred_taken", 32'(pred_taken_o), 32'd0);
        tick();
        chk_state("alloc", 32'h1010, 1'b1, 32'h1100);
        upd_valid_i = 0; stall_core_i = 0; tick();
        chk("follow_pred.pc", pc_o, 32'h1100);

        // Two not-taken updates: 2 -> 1 -> 0
        stall_core_i = 1; redir_i = 1; redir_pc_i = 32'h1010;
        upd_valid_i = 1; upd_taken_i = 0; tick();
        redir_i = 0;
        chk_state("nt1", 32'h1010, 1'b0, 32'h1014);
        tick();
        chk("nt2.pred_taken", 32'(pred_taken_o), 32'd0);

        // Four taken updates: 0 -> 1 -> 2 -> 3 -> 3
        upd_taken_i = 1; tick();
        chk("t1.pred_taken", 32'(pred_taken_o), 32'd0);
        tick();
        chk("t2.pred_taken", 32'(pred_taken_o), 32'd1);
        tick();
        chk("t3.pred_taken", 32'(pred_taken_o), 32'd1);
        tick();
        chk("t4.pred_taken", 32'(pred_taken_o), 32'd1);
        // Saturated at 3: one decrement stays taken, second drops to weak not-taken
        upd_taken_i = 0; tick();
        chk("sat_dec1.pred_taken", 32'(pred_taken_o), 32'd1);
        tick();
        chk("sat_dec2.pred_taken", 32'(pred_taken_o), 32'd0);
        upd_taken_i = 1; tick();
        chk_state("retrain", 32'h1010, 1'b1, 32'h1100);

        // Alias at 0x1050: same index, different tag
        upd_valid_i = 0; redir_i = 1; redir_pc_i = 32'h1050; tick();
        redir_i = 0;
        chk_state("alias_miss", 32'h1050, 1'b0, 32'h1054);
        upd_valid_i = 1; upd_pc_i = 32'h1050; upd_taken_i = 1; upd_target_i = 32'h1200;
        tick();
        chk_state("alias_alloc", 32'h1050, 1'b1, 32'h1200);
        // Not-taken miss at aliasing 0x1090 must leave the entry alone
        upd_pc_i = 32'h1090; upd_taken_i = 0; tick();
        chk_state("nt_miss_nochg", 32'h1050, 1'b1, 32'h1200);
        upd_valid_i = 0; redir_i = 1; redir_pc_i = 32'h1010; tick();
        redir_i = 0;
        chk_state("evicted", 32'h1010, 1'b0, 32'h1014);

        // PC wrap
        stall_core_i = 0; redir_i = 1; redir_pc_i = 32'hFFFF_FFFC; tick();
        redir_i = 0;
        chk_state("wrap_top", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
        tick();
        chk("wrap_zero.pc", pc_o, 32'h0000_0000);

        // Reset during an update clears the BTB and wins over the update
        stall_core_i = 1; redir_i = 1; redir_pc_i = 32'h1050; tick();
        redir_i = 0;
        chk("pre_rst.pred_taken", 32'(pred_taken_o), 32'd1);
        rst_i = 1; upd_valid_i = 1; upd_pc_i = 32'h1050; upd_taken_i = 1;
        upd_target_i = 32'h1300; tick();
        chk("rst_upd.pc", pc_o, 32'h1000);
        rst_i = 0; upd_valid_i = 0; redir_i = 1; redir_pc_i = 32'h1050; tick();
        redir_i = 0;
        chk_state("post_rst", 32'h1050, 1'b0, 32'h1054);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
